// File: rtl/bypass_arbiter.sv
// ---------------------------------------------------------------------------
// bypass_arbiter
//
// Collects uncached (bypass) miss requests from NR_PORTS data-cache
// controllers, picks one round-robin, and issues it as a single-beat
// transaction on the uncached memory port. The grant pulse goes back to the
// winner in the arbitration cycle. The response pulse (read data or write
// ack) goes back when the memory answers. Only one transaction is in flight
// at a time, so uncached accesses keep their order.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   miss_valid_i           per-port request valid
//   miss_bypass_i          per-port "uncached" qualifier (valid&bypass = eligible)
//   miss_addr_i/be/size/we/wdata   per-port request fields, packed port-major
//   bypass_gnt_o           one-cycle grant pulse to the winning port
//   bypass_valid_o         one-cycle response pulse to the owning port
//   bypass_data_o          shared response data (0 when no response pulse)
//   mem_req_o/mem_gnt_i    request handshake toward memory
//   mem_addr_o/we/be/size/wdata    request fields, held stable while requesting
//   mem_rvalid_i/rdata/err response from memory (one per request)
//   busy_o                 arbiter is not idle
//   err_count_o            saturating count of errored responses
// ---------------------------------------------------------------------------
module bypass_arbiter #(
    parameter int unsigned NR_PORTS   = 3,
    parameter int unsigned ADDR_WIDTH = 56
) (
    input  logic                             clk_i,
    input  logic                             rst_i,

    input  logic [NR_PORTS-1:0]              miss_valid_i,
    input  logic [NR_PORTS-1:0]              miss_bypass_i,
    input  logic [NR_PORTS*ADDR_WIDTH-1:0]   miss_addr_i,
    input  logic [NR_PORTS*8-1:0]            miss_be_i,
    input  logic [NR_PORTS*2-1:0]            miss_size_i,
    input  logic [NR_PORTS-1:0]              miss_we_i,
    input  logic [NR_PORTS*64-1:0]           miss_wdata_i,

    output logic [NR_PORTS-1:0]              bypass_gnt_o,
    output logic [NR_PORTS-1:0]              bypass_valid_o,
    output logic [63:0]                      bypass_data_o,

    output logic                             mem_req_o,
    input  logic                             mem_gnt_i,
    output logic [ADDR_WIDTH-1:0]            mem_addr_o,
    output logic                             mem_we_o,
    output logic [7:0]                       mem_be_o,
    output logic [1:0]                       mem_size_o,
    output logic [63:0]                      mem_wdata_o,
    input  logic                             mem_rvalid_i,
    input  logic [63:0]                      mem_rdata_i,
    input  logic                             mem_err_i,

    output logic                             busy_o,
    output logic [7:0]                       err_count_o
);

    localparam int unsigned IDX_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

    // Pointer starts at the last port so that port 0 is the first winner.
    localparam logic [IDX_W-1:0] RR_RESET = IDX_W'(NR_PORTS - 1);

    // Returned in place of read data when the memory flags an error.
    localparam logic [63:0] ERR_DATA = 64'hBADC_AB1E_BADC_AB1E;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RESP
    } state_e;

    // -----------------------------------------------------------------------
    // State and latched request
    // -----------------------------------------------------------------------
    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        rr_q;
    logic [IDX_W-1:0]        port_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]              be_q;
    logic [1:0]              size_q;
    logic                    we_q;
    logic [63:0]             wdata_q;
    logic [7:0]              err_count_q;

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------
    logic [NR_PORTS-1:0]     eligible;
    logic                    win_found;
    logic [IDX_W-1:0]        win_idx;
    logic [IDX_W-1:0]        cand;

    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [7:0]              sel_be;
    logic [1:0]              sel_size;
    logic                    sel_we;
    logic [63:0]             sel_wdata;

    // Control decoded from the FSM
    logic                    latch_en;
    logic                    err_inc;

    assign eligible = miss_valid_i & miss_bypass_i;

    // Walk the ports starting just after the last winner and take the first
    // eligible one. With the loop starting at offset 1 and ending at
    // NR_PORTS, the last winner itself is checked last, which gives fair
    // rotation. For NR_PORTS=1 every offset maps to port 0.
    always_comb begin
        // NOTE: every signal written in a combinational block gets a default
        // before any conditional assignment; otherwise a path leaves it
        // unassigned and a latch is inferred.
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= NR_PORTS; i++) begin
            cand = IDX_W'((32'(rr_q) + i) % NR_PORTS);
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Field multiplexer for the winning port. Constant slices per port keep
    // the selection a plain mux.
    always_comb begin
        sel_addr  = '0;
        sel_be    = '0;
        sel_size  = '0;
        sel_we    = 1'b0;
        sel_wdata = '0;
        for (int unsigned p = 0; p < NR_PORTS; p++) begin
            if (IDX_W'(p) == win_idx) begin
                sel_addr  = miss_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
                sel_be    = miss_be_i[p*8 +: 8];
                sel_size  = miss_size_i[p*2 +: 2];
                sel_we    = miss_we_i[p];
                sel_wdata = miss_wdata_i[p*64 +: 64];
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state and outputs
    // -----------------------------------------------------------------------
    // While rst_i is high all pulses stay low. A grant issued in that cycle
    // would be lost by the reset, and a response arriving then belongs to an
    // abandoned transaction.
    always_comb begin
        state_d        = state_q;
        bypass_gnt_o   = '0;
        bypass_valid_o = '0;
        bypass_data_o  = '0;
        mem_req_o      = 1'b0;
        latch_en       = 1'b0;
        err_inc        = 1'b0;

        if (!rst_i) begin
            unique case (state_q)
                IDLE: begin
                    if (win_found) begin
                        bypass_gnt_o = NR_PORTS'(1) << win_idx;
                        latch_en     = 1'b1;
                        state_d      = ISSUE;
                    end
                end

                ISSUE: begin
                    // Port inputs are ignored here. The request is driven
                    // purely from the latch, so it stays stable until granted.
                    mem_req_o = 1'b1;
                    if (mem_gnt_i) begin
                        state_d = WAIT_RESP;
                    end
                end

                WAIT_RESP: begin
                    if (mem_rvalid_i) begin
                        // The owner always gets its pulse, even if it has
                        // since dropped miss_valid_i.
                        bypass_valid_o = NR_PORTS'(1) << port_q;
                        if (mem_err_i) begin
                            bypass_data_o = ERR_DATA;
                            err_inc       = (err_count_q != 8'hFF);
                        end else if (!we_q) begin
                            bypass_data_o = mem_rdata_i;
                        end
                        state_d = IDLE;
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Sequential state
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of statement
            // order.
            state_q     <= IDLE;
            rr_q        <= RR_RESET;
            port_q      <= '0;
            addr_q      <= '0;
            be_q        <= '0;
            size_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            err_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (latch_en) begin
                port_q  <= win_idx;
                rr_q    <= win_idx;
                addr_q  <= sel_addr;
                be_q    <= sel_be;
                size_q  <= sel_size;
                we_q    <= sel_we;
                wdata_q <= sel_wdata;
            end
            if (err_inc) begin
                err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registered outputs
    // -----------------------------------------------------------------------
    assign mem_addr_o  = addr_q;
    assign mem_we_o    = we_q;
    assign mem_be_o    = be_q;
    assign mem_size_o  = size_q;
    assign mem_wdata_o = wdata_q;
    assign busy_o      = !rst_i && (state_q != IDLE);
    assign err_count_o = err_count_q;

    // -----------------------------------------------------------------------
    // Structural invariants
    // -----------------------------------------------------------------------
    gnt_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(bypass_gnt_o));

    valid_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(bypass_valid_o));

endmodule

// File: tb/tb_bypass_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bypass_arbiter
//
// Directed bench for bypass_arbiter (NR_PORTS=3, ADDR_WIDTH=56). Inputs change
// on the falling edge. Outputs are sampled 1 time unit later, well away from
// the rising edge.
// ---------------------------------------------------------------------------
module tb_bypass_arbiter;

    localparam int NP = 3;
    localparam int AW = 56;
    localparam logic [63:0] ERR_DATA = 64'hBADC_AB1E_BADC_AB1E;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [NP-1:0]     miss_valid = '0;
    logic [NP-1:0]     miss_bypass = '0;
    logic [NP*AW-1:0]  miss_addr = '0;
    logic [NP*8-1:0]   miss_be = '0;
    logic [NP*2-1:0]   miss_size = '0;
    logic [NP-1:0]     miss_we = '0;
    logic [NP*64-1:0]  miss_wdata = '0;
    logic [NP-1:0]     bypass_gnt;
    logic [NP-1:0]     bypass_valid;
    logic [63:0]       bypass_data;
    logic              mem_req;
    logic              mem_gnt = 1'b0;
    logic [AW-1:0]     mem_addr;
    logic              mem_we;
    logic [7:0]        mem_be;
    logic [1:0]        mem_size;
    logic [63:0]       mem_wdata;
    logic              mem_rvalid = 1'b0;
    logic [63:0]       mem_rdata = '0;
    logic              mem_err = 1'b0;
    logic              busy;
    logic [7:0]        err_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_i = ~clk_i;

    bypass_arbiter #(.NR_PORTS(NP), .ADDR_WIDTH(AW)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .miss_valid_i   (miss_valid),
        .miss_bypass_i  (miss_bypass),
        .miss_addr_i    (miss_addr),
        .miss_be_i      (miss_be),
        .miss_size_i    (miss_size),
        .miss_we_i      (miss_we),
        .miss_wdata_i   (miss_wdata),
        .bypass_gnt_o   (bypass_gnt),
        .bypass_valid_o (bypass_valid),
        .bypass_data_o  (bypass_data),
        .mem_req_o      (mem_req),
        .mem_gnt_i      (mem_gnt),
        .mem_addr_o     (mem_addr),
        .mem_we_o       (mem_we),
        .mem_be_o       (mem_be),
        .mem_size_o     (mem_size),
        .mem_wdata_o    (mem_wdata),
        .mem_rvalid_i   (mem_rvalid),
        .mem_rdata_i    (mem_rdata),
        .mem_err_i      (mem_err),
        .busy_o         (busy),
        .err_count_o    (err_count)
    );

    task automatic drive_port(input int p, input logic v, input logic b,
                              input logic [AW-1:0] a, input logic [7:0] be,
                              input logic [1:0] sz, input logic we,
                              input logic [63:0] wd);
        miss_valid[p]            = v;
        miss_bypass[p]           = b;
        miss_addr[p*AW +: AW]    = a;
        miss_be[p*8 +: 8]        = be;
        miss_size[p*2 +: 2]      = sz;
        miss_we[p]               = we;
        miss_wdata[p*64 +: 64]   = wd;
    endtask

    task automatic clear_ports();
        miss_valid = '0; miss_bypass = '0; miss_addr = '0; miss_be = '0;
        miss_size = '0; miss_we = '0; miss_wdata = '0;
    endtask

    // Reset held with every port eligible: nothing may leak out.
    task automatic test_reset();
        @(negedge clk_i);
        for (int p = 0; p < NP; p++) drive_port(p, 1'b1, 1'b1, AW'(p), 8'hFF, 2'd3, 1'b0, 64'h0);
        #1;
        vectors++; if (bypass_gnt !== 3'b000) begin miscompares++; $display("FAIL rst_gnt: got %b expected %b", bypass_gnt, 3'b000); end
        vectors++; if (bypass_valid !== 3'b000) begin miscompares++; $display("FAIL rst_valid: got %b expected %b", bypass_valid, 3'b000); end
        vectors++; if (bypass_data !== 64'h0) begin miscompares++; $display("FAIL rst_data: got %h expected %h", bypass_data, 64'h0); end
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_mem_req: got %b expected %b", mem_req, 1'b0); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected %b", busy, 1'b0); end
        vectors++; if (err_count !== 8'd0) begin miscompares++; $display("FAIL rst_err_count: got %0d expected %0d", err_count, 0); end
        @(negedge clk_i);
        rst_i = 1'b0;
        clear_ports();
        #1;
        vectors++; if (bypass_gnt !== 3'b000) begin miscompares++; $display("FAIL rst_idle_gnt: got %b expected %b", bypass_gnt, 3'b000); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_idle_busy: got %b expected %b", busy, 1'b0); end
    endtask

    // Port 0 read, zero-wait grant, response two cycles after the request.
    task automatic test_single_read();
        @(negedge clk_i);
        drive_port(0, 1'b1, 1'b1, 56'h1000_0008, 8'hFF, 2'd3, 1'b0, 64'h0);
        mem_gnt = 1'b1;
        #1;
        vectors++; if (bypass_gnt !== 3'b001) begin miscompares++; $display("FAIL rd_gnt: got %b expected %b", bypass_gnt, 3'b001); end
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rd_req_c0: got %b expected %b", mem_req, 1'b0); end
        @(negedge clk_i);
        miss_valid[0] = 1'b0;
        #1;
        vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL rd_req_c1: got %b expected %b", mem_req, 1'b1); end
        vectors++; if (mem_addr !== 56'h1000_0008) begin miscompares++; $display("FAIL rd_addr: got %h expected %h", mem_addr, 56'h1000_0008); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rd_we: got %b expected %b", mem_we, 1'b0); end
        vectors++; if (mem_size !== 2'd3) begin miscompares++; $display("FAIL rd_size: got %0d expected %0d", mem_size, 3); end
        vectors++; if (bypass_gnt !== 3'b000) begin miscompares++; $display("FAIL rd_gnt_c1: got %b expected %b", bypass_gnt, 3'b000); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rd_busy_c1: got %b expected %b", busy, 1'b1); end
        @(negedge clk_i);
        mem_gnt = 1'b0;
        #1;
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rd_req_c2: got %b expected %b", mem_req, 1'b0); end
        vectors++; if (bypass_valid !== 3'b000) begin miscompares++; $display("FAIL rd_valid_c2: got %b expected %b", bypass_valid, 3'b000); end
        @(negedge clk_i);
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h0123_4567_89AB_CDEF;
        #1;
        vectors++; if (bypass_valid !== 3'b001) begin miscompares++; $display("FAIL rd_valid: got %b expected %b", bypass_valid, 3'b001); end
        vectors++; if (bypass_data !== 64'h0123_4567_89AB_CDEF) begin miscompares++; $display("FAIL rd_data: got %h expected %h", bypass_data, 64'h0123_4567_89AB_CDEF); end
        @(negedge clk_i);
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        clear_ports();
        #1;
        vectors++; if (bypass_valid !== 3'b000) begin miscompares++; $display("FAIL rd_valid_after: got %b expected %b", bypass_valid, 3'b000); end
        vectors++; if (bypass_data !== 64'h0) begin miscompares++; $display("FAIL rd_data_after: got %h expected %h", bypass_data, 64'h0); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rd_busy_after: got %b expected %b", busy, 1'b0); end
    endtask

    // All three ports request continuously from reset: order 0,1,2,0 with
    // each grant in the cycle right after the previous response.
    task automatic test_back_to_back();
        int exp_port[4] = '{0, 1, 2, 0};
        logic [NP-1:0] exp_vec;
        logic [63:0]   rdata;
        @(negedge clk_i);
        rst_i = 1'b1;
        for (int p = 0; p < NP; p++) drive_port(p, 1'b1, 1'b1, AW'(56'hA00 + 56'(p) * 56'h40), 8'hFF, 2'd3, 1'b0, 64'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_vec = 3'b001 << exp_port[k];
            rdata   = 64'h1111_0000_0000_0000 + 64'(k);
            vectors++; if (bypass_gnt !== exp_vec) begin miscompares++; $display("FAIL b2b_gnt[%0d]: got %b expected %b", k, bypass_gnt, exp_vec); end
            @(negedge clk_i);
            mem_gnt = 1'b1;
            #1;
            vectors++; if (mem_addr !== AW'(56'hA00 + 56'(exp_port[k]) * 56'h40)) begin miscompares++; $display("FAIL b2b_addr[%0d]: got %h expected %h", k, mem_addr, AW'(56'hA00 + 56'(exp_port[k]) * 56'h40)); end
            @(negedge clk_i);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
            if (k == 3) miss_valid = '0;
            #1;
            vectors++; if (bypass_valid !== exp_vec) begin miscompares++; $display("FAIL b2b_valid[%0d]: got %b expected %b", k, bypass_valid, exp_vec); end
            vectors++; if (bypass_data !== rdata) begin miscompares++; $display("FAIL b2b_data[%0d]: got %h expected %h", k, bypass_data, rdata); end
            @(negedge clk_i);
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            #1;
        end
        vectors++; if (bypass_gnt !== 3'b000) begin miscompares++; $display("FAIL b2b_gnt_end: got %b expected %b", bypass_gnt, 3'b000); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_busy_end: got %b expected %b", busy, 1'b0); end
        clear_ports();
    endtask

    // Port 1 write with memory grant held off 4 cycles; fields must stay put
    // even though the port changes its inputs right after the grant.
    task automatic test_write_stall();
        @(negedge clk_i);
        drive_port(1, 1'b1, 1'b1, 56'h2000_0010, 8'h0F, 2'd2, 1'b1, 64'hDEAD);
        mem_gnt = 1'b0;
        #1;
        vectors++; if (bypass_gnt !== 3'b010) begin miscompares++; $display("FAIL wr_gnt: got %b expected %b", bypass_gnt, 3'b010); end
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk_i);
            if (c == 1) drive_port(1, 1'b0, 1'b1, 56'hFFFF, 8'hF0, 2'd0, 1'b0, 64'h0);
            mem_gnt = (c == 5);
            #1;
            vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL wr_req[%0d]: got %b expected %b", c, mem_req, 1'b1); end
            vectors++; if ({mem_addr, mem_be, mem_size, mem_we, mem_wdata} !== {56'h2000_0010, 8'h0F, 2'd2, 1'b1, 64'hDEAD})
                begin miscompares++; $display("FAIL wr_fields[%0d]: got %h/%h/%0d/%b/%h expected 2000010/0f/2/1/dead", c, mem_addr, mem_be, mem_size, mem_we, mem_wdata); end
        end
        @(negedge clk_i);
        mem_gnt = 1'b0;
        #1;
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL wr_req_after: got %b expected %b", mem_req, 1'b0); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL wr_busy_wait: got %b expected %b", busy, 1'b1); end
        @(negedge clk_i);
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        vectors++; if (bypass_valid !== 3'b010) begin miscompares++; $display("FAIL wr_valid: got %b expected %b", bypass_valid, 3'b010); end
        vectors++; if (bypass_data !== 64'h0) begin miscompares++; $display("FAIL wr_data: got %h expected %h", bypass_data, 64'h0); end
        @(negedge clk_i);
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        clear_ports();
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL wr_busy_end: got %b expected %b", busy, 1'b0); end
    endtask

    // Port 2 valid without bypass is never eligible; port 0 wins instead.
    task automatic test_bypass_filter();
        @(negedge clk_i);
        drive_port(2, 1'b1, 1'b0, 56'h7000, 8'hFF, 2'd3, 1'b0, 64'h0);
        drive_port(0, 1'b1, 1'b1, 56'h3000, 8'hFF, 2'd3, 1'b0, 64'h0);
        #1;
        vectors++; if (bypass_gnt !== 3'b001) begin miscompares++; $display("FAIL flt_gnt: got %b expected %b", bypass_gnt, 3'b001); end
        @(negedge clk_i);
        miss_valid[0] = 1'b0;
        mem_gnt = 1'b1;
        #1;
        vectors++; if (mem_addr !== 56'h3000) begin miscompares++; $display("FAIL flt_addr: got %h expected %h", mem_addr, 56'h3000); end
        @(negedge clk_i);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h5555;
        #1;
        vectors++; if (bypass_valid !== 3'b001) begin miscompares++; $display("FAIL flt_valid: got %b expected %b", bypass_valid, 3'b001); end
        vectors++; if (bypass_data !== 64'h5555) begin miscompares++; $display("FAIL flt_data: got %h expected %h", bypass_data, 64'h5555); end
        @(negedge clk_i);
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            #1;
            vectors++; if (bypass_gnt !== 3'b000) begin miscompares++; $display("FAIL flt_idle_gnt[%0d]: got %b expected %b", c, bypass_gnt, 3'b000); end
            vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL flt_idle_busy[%0d]: got %b expected %b", c, busy, 1'b0); end
        end
        clear_ports();
    endtask

    // 256 errored reads: error pattern every time, counter stops at 255.
    task automatic test_error_saturation();
        for (int i = 0; i < 256; i++) begin
            @(negedge clk_i);
            drive_port(0, 1'b1, 1'b1, 56'h4000, 8'hFF, 2'd3, 1'b0, 64'h0);
            #1;
            vectors++; if (bypass_gnt !== 3'b001) begin miscompares++; $display("FAIL err_gnt[%0d]: got %b expected %b", i, bypass_gnt, 3'b001); end
            vectors++; if (err_count !== 8'(i)) begin miscompares++; $display("FAIL err_count[%0d]: got %0d expected %0d", i, err_count, i); end
            @(negedge clk_i);
            miss_valid[0] = 1'b0;
            mem_gnt = 1'b1;
            @(negedge clk_i);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b1;
            mem_err    = 1'b1;
            mem_rdata  = 64'h77;
            #1;
            vectors++; if (bypass_valid !== 3'b001) begin miscompares++; $display("FAIL err_valid[%0d]: got %b expected %b", i, bypass_valid, 3'b001); end
            vectors++; if (bypass_data !== ERR_DATA) begin miscompares++; $display("FAIL err_data[%0d]: got %h expected %h", i, bypass_data, ERR_DATA); end
            @(negedge clk_i);
            mem_rvalid = 1'b0;
            mem_err    = 1'b0;
            mem_rdata  = '0;
        end
        @(negedge clk_i);
        #1;
        vectors++; if (err_count !== 8'd255) begin miscompares++; $display("FAIL err_count_sat: got %0d expected %0d", err_count, 255); end
        clear_ports();
    endtask

    // Reset lands while waiting for the response; the late response is dropped
    // and arbitration restarts from port 0.
    task automatic test_reset_in_wait();
        @(negedge clk_i);
        drive_port(1, 1'b1, 1'b1, 56'h5000, 8'hFF, 2'd3, 1'b0, 64'h0);
        #1;
        vectors++; if (bypass_gnt !== 3'b010) begin miscompares++; $display("FAIL rw_gnt: got %b expected %b", bypass_gnt, 3'b010); end
        @(negedge clk_i);
        miss_valid[1] = 1'b0;
        mem_gnt = 1'b1;
        #1;
        vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL rw_req: got %b expected %b", mem_req, 1'b1); end
        @(negedge clk_i);
        mem_gnt = 1'b0;
        rst_i   = 1'b1;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rw_busy_rst: got %b expected %b", busy, 1'b0); end
        @(negedge clk_i);
        rst_i      = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h9999;
        #1;
        vectors++; if (bypass_valid !== 3'b000) begin miscompares++; $display("FAIL rw_valid: got %b expected %b", bypass_valid, 3'b000); end
        vectors++; if (bypass_data !== 64'h0) begin miscompares++; $display("FAIL rw_data: got %h expected %h", bypass_data, 64'h0); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rw_busy: got %b expected %b", busy, 1'b0); end
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rw_req_after: got %b expected %b", mem_req, 1'b0); end
        vectors++; if (err_count !== 8'd0) begin miscompares++; $display("FAIL rw_err_count: got %0d expected %0d", err_count, 0); end
        @(negedge clk_i);
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        drive_port(0, 1'b1, 1'b1, 56'h6000, 8'hFF, 2'd3, 1'b0, 64'h0);
        drive_port(1, 1'b1, 1'b1, 56'h6100, 8'hFF, 2'd3, 1'b0, 64'h0);
        #1;
        vectors++; if (bypass_gnt !== 3'b001) begin miscompares++; $display("FAIL rw_regnt: got %b expected %b", bypass_gnt, 3'b001); end
        @(negedge clk_i);
        clear_ports();
        mem_gnt = 1'b1;
        #1;
        vectors++; if (mem_addr !== 56'h6000) begin miscompares++; $display("FAIL rw_addr: got %h expected %h", mem_addr, 56'h6000); end
        @(negedge clk_i);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hABCD;
        #1;
        vectors++; if (bypass_valid !== 3'b001) begin miscompares++; $display("FAIL rw_final_valid: got %b expected %b", bypass_valid, 3'b001); end
        @(negedge clk_i);
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_write_stall();
        test_bypass_filter();
        test_error_saturation();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
